// File: rtl/spi_mem_arbiter_pkg.sv
// Shared types and constants for the SPI memory arbiter.
package spi_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam logic ReqRead  = 1'b0;
  localparam logic ReqWrite = 1'b1;

  // Timer width; kept at least one bit so tiny timeouts still elaborate.
  function automatic int unsigned timer_width(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/spi_mem_arbiter_rr.sv
// Two-input round-robin grant; the port not served last wins a tie.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic       valid_o,
  output logic       gnt_o
);

  logic last_q, last_d;

  // Pick a winner and remember it once the caller accepts the grant.
  always_comb begin
    valid_o = |req_i;
    gnt_o   = (&req_i) ? ~last_q : req_i[1];
    last_d  = (accept_i && valid_o) ? gnt_o : last_q;
  end

  // Last-grant register; reset to 1 so port 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/spi_mem_arbiter.sv
// Serialises fetch (port 0) and load/store (port 1) onto one SPI memory interface.
module spi_mem_arbiter
  import spi_mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter bit          P0_READ_ONLY   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req_i,
  input  logic        p0_we_i,
  input  logic [15:0] p0_addr_i,
  input  logic [15:0] p0_wdata_i,
  output logic [15:0] p0_rdata_o,
  output logic        p0_done_o,
  output logic        p0_err_o,
  input  logic        p1_req_i,
  input  logic        p1_we_i,
  input  logic [15:0] p1_addr_i,
  input  logic [15:0] p1_wdata_i,
  output logic [15:0] p1_rdata_o,
  output logic        p1_done_o,
  output logic        p1_err_o,
  output logic        mem_request_o,
  output logic        mem_request_type_o,
  output logic [15:0] mem_address_o,
  output logic [15:0] mem_write_data_o,
  input  logic [15:0] mem_data_out_i,
  input  logic        mem_ready_i,
  input  logic        mem_write_complete_i,
  output logic        busy_o,
  output logic        grant_o
);

  localparam int unsigned         TimerW    = timer_width(TIMEOUT_CYCLES);
  localparam logic [TimerW-1:0]   TimerLast = TimerW'(TIMEOUT_CYCLES - 1);
  localparam logic [TimerW-1:0]   TimerMax  = '1;

  state_e            state_q, state_d;
  logic              grant_q, grant_d;
  logic              type_q, type_d;
  logic [15:0]       addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              err_q, err_d;
  logic [15:0]       rdata0_q, rdata0_d;
  logic [15:0]       rdata1_q, rdata1_d;

  logic arb_valid, arb_gnt, complete;

  rr_arbiter2 u_rr (
    .clk      (clk),
    .reset    (reset),
    .req_i    ({p1_req_i, p0_req_i}),
    .accept_i (state_q == StIdle),
    .valid_o  (arb_valid),
    .gnt_o    (arb_gnt)
  );

  // Next-state and datapath capture for the transaction FSM.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    type_d   = type_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    timer_d  = timer_q;
    err_d    = err_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    // Only the pulse matching the latched type completes the transaction.
    complete = (type_q == ReqWrite) ? mem_write_complete_i : mem_ready_i;
    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          grant_d = arb_gnt;
          addr_d  = arb_gnt ? p1_addr_i : p0_addr_i;
          wdata_d = arb_gnt ? p1_wdata_i : p0_wdata_i;
          type_d  = arb_gnt ? p1_we_i : (P0_READ_ONLY ? ReqRead : p0_we_i);
          state_d = StIssue;
        end
      end
      StIssue: begin
        timer_d = '0;
        state_d = StWait;
      end
      StWait: begin
        if (complete) begin
          err_d   = 1'b0;
          state_d = StDone;
          if (type_q == ReqRead) begin
            if (grant_q) rdata1_d = mem_data_out_i;
            else         rdata0_d = mem_data_out_i;
          end
        end else if (timer_q == TimerLast) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else if (timer_q != TimerMax) begin
          timer_d = timer_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      grant_q  <= 1'b0;
      type_q   <= ReqRead;
      addr_q   <= '0;
      wdata_q  <= '0;
      timer_q  <= '0;
      err_q    <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      type_q   <= type_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      timer_q  <= timer_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign mem_request_o      = (state_q == StIssue);
  assign mem_request_type_o = type_q;
  assign mem_address_o      = addr_q;
  assign mem_write_data_o   = wdata_q;
  assign busy_o             = (state_q != StIdle);
  assign grant_o            = grant_q;
  assign p0_rdata_o         = rdata0_q;
  assign p1_rdata_o         = rdata1_q;
  assign p0_done_o          = (state_q == StDone) && !grant_q;
  assign p1_done_o          = (state_q == StDone) && grant_q;
  assign p0_err_o           = p0_done_o && err_q;
  assign p1_err_o           = p1_done_o && err_q;

endmodule
